sim_frame_tracker: RTL

Frame counter and dump-window sequencer for the simulation test harness. It sits directly upstream of the waveform-dump block. It watches the game's vertical sync and the ROM-download indicator and produces the 32-bit frame count, a dump-enable window and an end-of-simulation request that the dump logic and the testbench consume. It is fully synchronous to the game clock so that frame numbering is cycle-exact and reproducible between simulators.

---
 rtl/sim_frame_tracker_if.sv | 19 +
 rtl/sim_frame_tracker.sv | 95 +++++++++
 2 files changed

// File: rtl/sim_frame_tracker_if.sv
// sim_frame_tracker_if: harness-side sync inputs and frame/dump status outputs
interface sim_frame_tracker_if;
  logic        vs;
  logic        downloading;
  logic [31:0] frame_cnt;
  logic        vs_fall;
  logic        dwn_done;
  logic        dump_en;
  logic        dump_start;
  logic        finish_req;
  modport master (
    output vs, downloading,
    input  frame_cnt, vs_fall, dwn_done, dump_en, dump_start, finish_req
  );
  modport slave (
    input  vs, downloading,
    output frame_cnt, vs_fall, dwn_done, dump_en, dump_start, finish_req
  );
endinterface

// File: rtl/sim_frame_tracker.sv
// sim_frame_tracker: frame counter and dump-window sequencer driven by vsync and ROM download
module sim_frame_tracker #(
  parameter bit          LOADROM     = 1'b1,
  parameter logic [31:0] START_FRAME = 32'd0,
  parameter logic [31:0] STOP_FRAME  = 32'd0,
  parameter logic [31:0] MAXFRAMES   = 32'd0
) (
  input logic clk,
  input logic rst_n,
  sim_frame_tracker_if.slave s
);
  typedef enum logic [1:0] {WAIT_DWN, ARMED, DUMPING, DONE} state_t;
  state_t      st_q, st_d;
  logic [2:0]  vs_q, dl_q;
  logic        rdy_q, vs_fall_q, dwn_done_q, dwn_rise_q;
  logic        dump_en_q, dump_en_d, dump_start_q, dump_start_d;
  logic        finish_q, finish_d, fin_lat_q, fin_lat_d;
  logic [31:0] cnt_q, cnt_d, nxt;
  logic        inc, start_hit, stop_hit;
  always_comb begin
    nxt          = cnt_q + 32'd1;
    inc          = vs_fall_q && cnt_q != '1;
    start_hit    = START_FRAME == 32'd0 || (inc && nxt == START_FRAME);
    stop_hit     = STOP_FRAME != 32'd0 && inc && nxt == STOP_FRAME;
    st_d         = st_q;
    cnt_d        = cnt_q;
    dump_en_d    = dump_en_q;
    dump_start_d = 1'b0;
    finish_d     = 1'b0;
    fin_lat_d    = fin_lat_q;
    if (LOADROM && dwn_rise_q) begin
      st_d      = WAIT_DWN;
      cnt_d     = '0;
      dump_en_d = 1'b0;
      fin_lat_d = 1'b0;
    end else if (rdy_q) begin
      if (st_q != WAIT_DWN && inc) begin
        cnt_d = nxt;
        if (MAXFRAMES != 32'd0 && nxt == MAXFRAMES && !fin_lat_q) begin
          finish_d  = 1'b1;
          fin_lat_d = 1'b1;
        end
      end
      case (st_q)
        WAIT_DWN: st_d = dwn_done_q ? ARMED : WAIT_DWN;
        // a window that opens and closes on the same frame skips straight to DONE
        ARMED: if (start_hit) begin
          dump_start_d = 1'b1;
          dump_en_d    = !stop_hit;
          st_d         = stop_hit ? DONE : DUMPING;
        end
        DUMPING: if (stop_hit) begin
          st_d      = DONE;
          dump_en_d = 1'b0;
        end
        default: st_d = st_q;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q         <= LOADROM ? WAIT_DWN : ARMED;
      vs_q         <= '1;
      dl_q         <= '0;
      rdy_q        <= 1'b0;
      vs_fall_q    <= 1'b0;
      dwn_done_q   <= 1'b0;
      dwn_rise_q   <= 1'b0;
      cnt_q        <= '0;
      dump_en_q    <= 1'b0;
      dump_start_q <= 1'b0;
      finish_q     <= 1'b0;
      fin_lat_q    <= 1'b0;
    end else begin
      st_q         <= st_d;
      vs_q         <= {vs_q[1:0], s.vs};
      dl_q         <= {dl_q[1:0], s.downloading};
      rdy_q        <= 1'b1;
      vs_fall_q    <= vs_q[2] & ~vs_q[1];
      dwn_done_q   <= dl_q[2] & ~dl_q[1];
      dwn_rise_q   <= ~dl_q[2] & dl_q[1];
      cnt_q        <= cnt_d;
      dump_en_q    <= dump_en_d;
      dump_start_q <= dump_start_d;
      finish_q     <= finish_d;
      fin_lat_q    <= fin_lat_d;
    end
  end
  assign s.frame_cnt  = cnt_q;
  assign s.vs_fall    = vs_fall_q;
  assign s.dwn_done   = dwn_done_q;
  assign s.dump_en    = dump_en_q;
  assign s.dump_start = dump_start_q;
  assign s.finish_req = finish_q;
endmodule
